// File: rtl/tile_pick_ctrl.sv
// Pick-key front-end for the in-game stage: debounced key, tile sampling, pair handshake.
// Optional undo key is built in when TILE_PICK_UNDO_EN is defined.

module tile_pick_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic pulse_o
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_prev_q, pulse_q;
   logic [CNT_W-1:0] cnt_q;

   // A 1-bit key that changes while differing from the level now equals it, so one clear covers both cases.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         pulse_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= raw_i;
         sync2_q      <= sync1_q;
         level_prev_q <= level_q;
         pulse_q      <= level_q & ~level_prev_q;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign pulse_o = pulse_q;
endmodule

// state        | meaning
// S_IDLE       | no game running, outputs quiet
// S_WAIT_FIRST | waiting for the first tile of a move
// S_WAIT_SECOND| first tile held, waiting for the second
// S_OFFER      | pair offered to ingameFSM, waiting for pair_ready
module tile_pick_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TILE_W          = 4,
   parameter int NUM_TILES       = 16
) (
   input  logic                 CLOCK_50,
   input  logic                 userquit,
   input  logic                 ingameOn,
   input  logic                 key_pick,
   input  logic [TILE_W-1:0]    tile_sw,
   input  logic [NUM_TILES-1:0] tile_matched,
   input  logic                 pair_ready,
`ifdef TILE_PICK_UNDO_EN
   input  logic                 key_undo,
`endif
   output logic                 pair_valid,
   output logic [TILE_W-1:0]    pair_first,
   output logic [TILE_W-1:0]    pair_second,
   output logic                 first_held,
   output logic                 pick_reject,
   output logic [7:0]           move_count
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT_FIRST, S_WAIT_SECOND, S_OFFER} state_t;

   localparam logic [TILE_W:0] NUM_TILES_L = (TILE_W+1)'(NUM_TILES);

   state_t              state_q, state_d;
   logic [TILE_W-1:0]   tile_s1_q, tile_s2_q;
   logic                ingame_prev_q;
   logic                pick, undo, start, handshake;
   logic                in_range, legal_first, legal_second;
   logic                pair_valid_q, pair_valid_d;
   logic [TILE_W-1:0]   pair_first_q, pair_first_d;
   logic [TILE_W-1:0]   pair_second_q, pair_second_d;
   logic                first_held_q, first_held_d;
   logic                pick_reject_q, pick_reject_d;
   logic [7:0]          move_count_q, move_count_d;

   tile_pick_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pick_db (
      .clk     (CLOCK_50),
      .rst     (userquit),
      .raw_i   (key_pick),
      .pulse_o (pick)
   );

`ifdef TILE_PICK_UNDO_EN
   tile_pick_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo_db (
      .clk     (CLOCK_50),
      .rst     (userquit),
      .raw_i   (key_undo),
      .pulse_o (undo)
   );
`else
   assign undo = 1'b0;
`endif

   assign start        = ingameOn & ~ingame_prev_q;
   assign handshake    = pair_valid_q & pair_ready;
   assign in_range     = {1'b0, tile_s2_q} < NUM_TILES_L;
   assign legal_first  = in_range && !tile_matched[tile_s2_q];
   assign legal_second = legal_first && (tile_s2_q != pair_first_q);

   always_ff @(posedge CLOCK_50) begin
      if (userquit) begin
         state_q       <= S_IDLE;
         tile_s1_q     <= '0;
         tile_s2_q     <= '0;
         ingame_prev_q <= 1'b0;
         pair_valid_q  <= 1'b0;
         pair_first_q  <= '0;
         pair_second_q <= '0;
         first_held_q  <= 1'b0;
         pick_reject_q <= 1'b0;
         move_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         tile_s1_q     <= tile_sw;
         tile_s2_q     <= tile_s1_q;
         ingame_prev_q <= ingameOn;
         pair_valid_q  <= pair_valid_d;
         pair_first_q  <= pair_first_d;
         pair_second_q <= pair_second_d;
         first_held_q  <= first_held_d;
         pick_reject_q <= pick_reject_d;
         move_count_q  <= move_count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:        if (start) state_d = S_WAIT_FIRST;
         S_WAIT_FIRST:  if (!ingameOn) state_d = S_IDLE;
                        else if (pick && legal_first) state_d = S_WAIT_SECOND;
         S_WAIT_SECOND: if (!ingameOn) state_d = S_IDLE;
                        else if (undo) state_d = S_WAIT_FIRST;
                        else if (pick && legal_second) state_d = S_OFFER;
         S_OFFER:       if (!ingameOn) state_d = S_IDLE;
                        else if (handshake) state_d = S_WAIT_FIRST;
         default:       state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pair_valid_d  = pair_valid_q;
      pair_first_d  = pair_first_q;
      pair_second_d = pair_second_q;
      first_held_d  = first_held_q;
      pick_reject_d = 1'b0;
      move_count_d  = move_count_q;
      if (state_q == S_IDLE || !ingameOn) begin
         pair_valid_d = 1'b0;
         first_held_d = 1'b0;
         if (state_q == S_IDLE && start) move_count_d = '0;
      end else begin
         unique case (state_q)
            S_WAIT_FIRST: if (pick) begin
               if (legal_first) begin
                  pair_first_d = tile_s2_q;
                  first_held_d = 1'b1;
               end else begin
                  pick_reject_d = 1'b1;
               end
            end
            S_WAIT_SECOND: if (undo) begin
               first_held_d = 1'b0;
            end else if (pick) begin
               if (legal_second) begin
                  pair_second_d = tile_s2_q;
                  pair_valid_d  = 1'b1;
               end else begin
                  pick_reject_d = 1'b1;
               end
            end
            S_OFFER: if (handshake) begin
               pair_valid_d = 1'b0;
               first_held_d = 1'b0;
               move_count_d = (move_count_q == 8'hFF) ? 8'hFF : move_count_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign pair_valid  = pair_valid_q;
   assign pair_first  = pair_first_q;
   assign pair_second = pair_second_q;
   assign first_held  = first_held_q;
   assign pick_reject = pick_reject_q;
   assign move_count  = move_count_q;
endmodule

// File: tb/tb_tile_pick_ctrl.sv
// Bench for tile_pick_ctrl with a short debounce; undo steps run when TILE_PICK_UNDO_EN is defined.
module tb_tile_pick_ctrl;
   localparam int D = 4;

   logic        CLOCK_50 = 1'b0;
   logic        userquit = 1'b1;
   logic        ingameOn = 1'b0;
   logic        key_pick = 1'b0;
   logic [3:0]  tile_sw = '0;
   logic [15:0] tile_matched = '0;
   logic        pair_ready = 1'b0;
`ifdef TILE_PICK_UNDO_EN
   logic        key_undo = 1'b0;
`endif
   logic        pair_valid;
   logic [3:0]  pair_first, pair_second;
   logic        first_held, pick_reject;
   logic [7:0]  move_count;

   tile_pick_ctrl #(.DEBOUNCE_CYCLES(D), .TILE_W(4), .NUM_TILES(16)) dut (
      .CLOCK_50     (CLOCK_50),
      .userquit     (userquit),
      .ingameOn     (ingameOn),
      .key_pick     (key_pick),
      .tile_sw      (tile_sw),
      .tile_matched (tile_matched),
      .pair_ready   (pair_ready),
`ifdef TILE_PICK_UNDO_EN
      .key_undo     (key_undo),
`endif
      .pair_valid   (pair_valid),
      .pair_first   (pair_first),
      .pair_second  (pair_second),
      .first_held   (first_held),
      .pick_reject  (pick_reject),
      .move_count   (move_count)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int total = 0, bad = 0;
   int rej_seen = 0, acc_seen = 0, valid_cycles = 0;
   logic [3:0] cap_first = '0, cap_second = '0;

   always @(negedge CLOCK_50) begin
      if (pick_reject) rej_seen++;
      if (pair_valid) begin
         valid_cycles++;
         cap_first  = pair_first;
         cap_second = pair_second;
         if (pair_ready) acc_seen++;
      end
   end

   // Reference model: the tiles picked so far in the current move, plus game/score bookkeeping.
   bit game_on = 0;
   int held[$];
   int m_moves = 0, m_rejects = 0, m_accepts = 0;

   task automatic model_start();
      game_on = 1; m_moves = 0; held.delete();
   endtask

   task automatic model_stop();
      game_on = 0; held.delete();
   endtask

   task automatic model_pick(input int idx);
      bit legal;
      if (!game_on || held.size() == 2) return;
      legal = (idx < 16) && !tile_matched[idx];
      if (held.size() == 1 && held[0] == idx) legal = 0;
      if (legal) held.push_back(idx);
      else m_rejects++;
   endtask

   task automatic model_accept();
      if (held.size() != 2) return;
      held.delete();
      m_accepts++;
      if (m_moves < 255) m_moves++;
   endtask

   task automatic model_undo();
      if (game_on && held.size() == 1) held.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, pair_valid, (game_on && held.size() == 2) ? 1 : 0);
      chk({tag, ".held"}, first_held, (game_on && held.size() >= 1) ? 1 : 0);
      if (held.size() >= 1) chk({tag, ".first"}, pair_first, held[0]);
      if (held.size() == 2) chk({tag, ".second"}, pair_second, held[1]);
      chk({tag, ".moves"}, move_count, m_moves);
      chk({tag, ".rejects"}, rej_seen, m_rejects);
      chk({tag, ".accepts"}, acc_seen, m_accepts);
   endtask

   task automatic press_pick(input int idx);
      if (pair_ready && held.size() == 2) model_accept();
      tile_sw = idx[3:0];
      key_pick = 1'b1; tick(6);
      key_pick = 1'b0; tick(14);
      model_pick(idx);
      if (pair_ready && held.size() == 2) model_accept();
   endtask

   task automatic do_accept();
      pair_ready = 1'b1; tick(1);
      pair_ready = 1'b0;
      model_accept();
   endtask

`ifdef TILE_PICK_UNDO_EN
   task automatic press_undo();
      key_undo = 1'b1; tick(6);
      key_undo = 1'b0; tick(14);
      model_undo();
   endtask
`endif

   initial begin
      int vc0;
      tick(3);
      chk("rst.valid", pair_valid, 0);
      chk("rst.held", first_held, 0);
      chk("rst.reject", pick_reject, 0);
      chk("rst.moves", move_count, 0);
      chk("rst.first", pair_first, 0);
      chk("rst.second", pair_second, 0);
      userquit = 1'b0;
      ingameOn = 1'b1; model_start();
      tick(2);
      check_all("start");

      // Basic move with pair_ready held high.
      pair_ready = 1'b1;
      press_pick(3);
      check_all("t1.first");
      vc0 = valid_cycles;
      press_pick(7);
      chk("t1.valid_len", valid_cycles - vc0, 1);
      chk("t1.cap_first", cap_first, 3);
      chk("t1.cap_second", cap_second, 7);
      check_all("t1.done");
      pair_ready = 1'b0;

      // Glitch rejected; a held press lands 2+D+1 cycles later and the FSM reacts one edge after.
      tile_sw = 4'd9;
      key_pick = 1'b1; tick(3);
      key_pick = 1'b0; tick(15);
      check_all("t2.glitch");
      key_pick = 1'b1; tick(6);
      key_pick = 1'b0; tick(1);
      chk("t2.early", first_held, 0);
      tick(1);
      chk("t2.ontime", first_held, 1);
      chk("t2.first", pair_first, 9);
      tick(14);
      model_pick(9);
      check_all("t2.single");

      // Offer held with pair_ready low; extra pick ignored.
      press_pick(1);
      check_all("t4.offer");
      tick(10);
      press_pick(4);
      check_all("t4.stable");
      do_accept();
      check_all("t4.accept");

      // Matched tile, duplicate second, highest index.
      tile_matched = 16'h0020;
      press_pick(5);
      check_all("t3.matched");
      press_pick(2);
      press_pick(2);
      check_all("t3.dup");
      press_pick(15);
      check_all("t3.top");
      do_accept();
      check_all("t3.accept");

      // Random play until the score counter has saturated for a while.
      for (int it = 0; it < 2000 && m_accepts < 262; it++) begin
         tile_matched = 16'($urandom & $urandom & $urandom);
         pair_ready = 1'($urandom_range(0, 3) == 0);
         press_pick($urandom_range(0, 15));
         pair_ready = 1'b0;
         if (held.size() == 2 && $urandom_range(0, 1) == 1) do_accept();
         check_all("rand");
      end
      chk("sat.moves", move_count, 255);

      // Game stop in WAIT_SECOND and restart.
      tile_matched = '0;
      if (held.size() == 2) do_accept();
      if (held.size() == 0) press_pick(6);
      check_all("t5.wait2");
      ingameOn = 1'b0; model_stop();
      tick(1);
      check_all("t5.stop");
      tick(3);
      chk("t5.kept", move_count, 255);
      ingameOn = 1'b1; model_start();
      tick(1);
      check_all("t5.restart");

`ifdef TILE_PICK_UNDO_EN
      press_pick(4);
      check_all("t6.pick");
      press_undo();
      check_all("t6.undo");
      press_undo();
      check_all("t6.undo_idle");
      press_pick(8);
      check_all("t6.repick");
      press_pick(12);
      do_accept();
      check_all("t6.accept");
`endif

      // userquit beats a same-cycle handshake.
      press_pick(10);
      press_pick(11);
      check_all("q.offer");
      pair_ready = 1'b1; userquit = 1'b1;
      tick(1);
      chk("q.valid", pair_valid, 0);
      chk("q.held", first_held, 0);
      chk("q.moves", move_count, 0);
      userquit = 1'b0; pair_ready = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
